// File: rtl/iir_filter.sv
// iir_filter
//   Second-order IIR filter on 8-bit signed samples, built around one 8x8
//   signed multiplier and one 20-bit accumulator shared over five cycles.
//     y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + c1*y[n-1] + c2*y[n-2]
//   Coefficients are Q1.7; the full-precision sum is floored by 2^7 and
//   saturated to the 8-bit range before it is output and fed back.
//
// Ports
//   clk_i     in   1  clock, rising edge
//   rst_i     in   1  synchronous active-high reset
//   en_i      in   1  sample request, honoured only while idle
//   d_in      in   8  signed input sample x[n]
//   result_o  out  8  signed filtered sample y[n], held between updates
//   valid_o   out  1  one-cycle pulse when result_o updates
//   busy_o    out  1  high while a sample is in flight
module iir_filter (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic signed [7:0] d_in,
  output logic signed [7:0] result_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam logic signed [7:0]  B0      = 8'sh20;
  localparam logic signed [7:0]  B1      = 8'sh40;
  localparam logic signed [7:0]  B2      = 8'sh20;
  localparam logic signed [7:0]  C1      = 8'sh40;
  localparam logic signed [7:0]  C2      = 8'shE0;
  localparam logic signed [19:0] SAT_MAX = 20'sd127;
  localparam logic signed [19:0] SAT_MIN = -20'sd128;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic signed [19:0] acc_q, acc_d;
  logic signed [7:0]  x0_q, x0_d;
  logic signed [7:0]  x1_q, x1_d;
  logic signed [7:0]  x2_q, x2_d;
  logic signed [7:0]  y1_q, y1_d;
  logic signed [7:0]  y2_q, y2_d;
  logic signed [7:0]  result_q, result_d;
  logic               valid_q, valid_d;

  logic signed [7:0]  coef;
  logic signed [7:0]  operand;
  logic signed [15:0] product;
  logic signed [19:0] acc_sum;
  logic signed [19:0] shifted;
  logic signed [7:0]  sat_result;

  // The count selects which coefficient/history pair feeds the single
  // multiplier this cycle.
  always_comb begin
    coef    = B0;
    operand = x0_q;
    case (count_q)
      3'd0: begin coef = B0; operand = x0_q; end
      3'd1: begin coef = B1; operand = x1_q; end
      3'd2: begin coef = B2; operand = x2_q; end
      3'd3: begin coef = C1; operand = y1_q; end
      3'd4: begin coef = C2; operand = y2_q; end
      default: begin coef = B0; operand = x0_q; end
    endcase
  end

  // Product is sign-extended into the accumulator. The five-term sum is
  // bounded by 5*2^14, well inside 20 bits, so no intermediate clipping.
  // The arithmetic shift floors toward minus infinity.
  always_comb begin
    product = coef * operand;
    acc_sum = acc_q + $signed({{4{product[15]}}, product});
    shifted = acc_sum >>> 7;
    if (shifted > SAT_MAX) begin
      sat_result = 8'sh7F;
    end else if (shifted < SAT_MIN) begin
      sat_result = 8'sh80;
    end else begin
      sat_result = shifted[7:0];
    end
  end

  // Next-state logic. The final product is folded in combinationally on the
  // count=4 edge so the result lands in the same edge that leaves MAC. The
  // delay lines only advance when leaving OUT, so a reset mid-sample leaves
  // no trace of the discarded sample in the history.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          x0_d    = d_in;
          acc_d   = '0;
          count_d = 3'd0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d   = acc_sum;
        count_d = count_q + 3'd1;
        if (count_q == 3'd4) begin
          result_d = sat_result;
          valid_d  = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        x2_d    = x1_q;
        x1_d    = x0_q;
        y2_d    = y1_q;
        y1_d    = result_q;
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_iir_filter.sv
// tb_iir_filter
//   Self-checking bench for iir_filter. A behavioural reference tracks the
//   sample timing and the filter arithmetic; expected outputs are queued when
//   a sample is accepted and compared when valid_o pulses.
module tb_iir_filter;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              en_i  = 1'b0;
  logic signed [7:0] d_in  = '0;
  logic signed [7:0] result_o;
  logic              valid_o;
  logic              busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state
  int                m_phase = 0;
  logic signed [7:0] m_x0 = '0, m_x1 = '0, m_x2 = '0;
  logic signed [7:0] m_y1 = '0, m_y2 = '0;
  logic signed [7:0] m_pend = '0, m_result = '0;
  logic signed [7:0] exp_q[$];

  logic signed [7:0] imp_ref  [5] = '{8'sd31, 8'sd79, 8'sd63, 8'sd11, -8'sd11};
  logic signed [7:0] step_ref [3] = '{8'sd31, 8'sd110, 8'sd127};

  iir_filter dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .d_in     (d_in),
    .result_o (result_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic signed [7:0] model_y(
    input logic signed [7:0] x0, input logic signed [7:0] x1,
    input logic signed [7:0] x2, input logic signed [7:0] y1,
    input logic signed [7:0] y2);
    int s;
    int f;
    s = 32 * int'(x0) + 64 * int'(x1) + 32 * int'(x2) + 64 * int'(y1) - 32 * int'(y2);
    f = s >>> 7;
    if (f > 127) f = 127;
    if (f < -128) f = -128;
    return f[7:0];
  endfunction

  // Drive one cycle of inputs, advance the reference across the edge, and
  // leave time 1 unit after the edge so outputs are sampled off the edge.
  task automatic step(input logic en, input logic signed [7:0] din);
    en_i = en;
    d_in = din;
    @(posedge clk_i);
    if (rst_i) begin
      m_phase = 0;
      m_x0 = '0; m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
      m_pend = '0; m_result = '0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (en) begin
        m_x0   = din;
        m_pend = model_y(din, m_x1, m_x2, m_y1, m_y2);
        exp_q.push_back(m_pend);
        m_phase = 1;
      end
    end else if (m_phase < 5) begin
      m_phase++;
    end else if (m_phase == 5) begin
      m_result = m_pend;
      m_phase  = 6;
    end else begin
      m_x2 = m_x1; m_x1 = m_x0; m_y2 = m_y1; m_y1 = m_result;
      m_phase = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'sh55);
      tests_run++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 8'sd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_state: busy=%b valid=%b result=%0d, required 0 0 0",
                 busy_o, valid_o, result_o);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_idle();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'($urandom));
      tests_run++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 8'sd0) begin
        tests_failed++;
        $display("[TB] FAIL idle cycle %0d: busy=%b valid=%b result=%0d, required 0 0 0",
                 i, busy_o, valid_o, result_o);
      end
    end
  endtask

  // Impulse from zero history; checks each result against the reference
  // queue and against the hand-derived constants.
  task automatic test_impulse(input int n_res);
    logic signed [7:0] exp;
    int k;
    k = 0;
    for (int i = 0; i < 7 * n_res + 10 && k < n_res; i++) begin
      step(1'b1, (i == 0) ? 8'sh7F : 8'sh00);
      tests_run++;
      if (busy_o !== (m_phase != 0) || valid_o !== (m_phase == 6)) begin
        tests_failed++;
        $display("[TB] FAIL impulse_timing cycle %0d: busy=%b valid=%b, required %b %b",
                 i, busy_o, valid_o, m_phase != 0, m_phase == 6);
      end
      if (valid_o === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL impulse_unexpected: result=%0d with nothing expected", result_o);
        end else begin
          exp = exp_q.pop_front();
          if (result_o !== exp || result_o !== imp_ref[k]) begin
            tests_failed++;
            $display("[TB] FAIL impulse[%0d]: result=%0d, required %0d (model %0d)",
                     k, result_o, imp_ref[k], exp);
          end
        end
        k++;
      end
    end
    tests_run++;
    if (k < n_res) begin
      tests_failed++;
      $display("[TB] FAIL impulse_timeout: got %0d results, required %0d", k, n_res);
    end
  endtask

  task automatic test_step();
    logic signed [7:0] exp;
    int k;
    apply_reset();
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      step(1'b1, 8'sh7F);
      tests_run++;
      if (busy_o !== (m_phase != 0) || valid_o !== (m_phase == 6)) begin
        tests_failed++;
        $display("[TB] FAIL step_timing cycle %0d: busy=%b valid=%b, required %b %b",
                 i, busy_o, valid_o, m_phase != 0, m_phase == 6);
      end
      if (valid_o === 1'b1) begin
        tests_run++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'sd0;
        if (result_o !== exp || (k < 3 && result_o !== step_ref[k])) begin
          tests_failed++;
          $display("[TB] FAIL step[%0d]: result=%0d, required %0d", k, result_o, exp);
        end
        k++;
      end
    end
    tests_run++;
    if (k < 4) begin
      tests_failed++;
      $display("[TB] FAIL step_timeout: got %0d results, required 4", k);
    end
  endtask

  // en_i held high: valid_o one cycle wide, exactly 7 cycles apart, and
  // d_in changing every cycle must not disturb an in-flight sample.
  task automatic test_back_to_back();
    logic signed [7:0] exp;
    int last;
    int pulses;
    logic prev_valid;
    apply_reset();
    last = -1;
    pulses = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 7 * 8; i++) begin
      step(1'b1, 8'($urandom));
      tests_run++;
      if (busy_o !== (m_phase != 0) || valid_o !== (m_phase == 6)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_timing cycle %0d: busy=%b valid=%b, required %b %b",
                 i, busy_o, valid_o, m_phase != 0, m_phase == 6);
      end
      if (valid_o === 1'b1) begin
        pulses++;
        tests_run++;
        if (prev_valid === 1'b1 || (last >= 0 && i - last != 7)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_spacing cycle %0d: gap=%0d prev_valid=%b, required gap 7 prev 0",
                   i, i - last, prev_valid);
        end
        last = i;
        tests_run++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'sd0;
        if (result_o !== exp) begin
          tests_failed++;
          $display("[TB] FAIL b2b_result cycle %0d: result=%0d, required %0d", i, result_o, exp);
        end
      end
      prev_valid = valid_o;
    end
    tests_run++;
    if (pulses != 8) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: pulses=%0d, required 8", pulses);
    end
  endtask

  // Random en_i and d_in; result_o must hold whenever valid_o is low.
  task automatic test_random();
    logic signed [7:0] exp;
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom));
      tests_run++;
      if (busy_o !== (m_phase != 0) || valid_o !== (m_phase == 6) || result_o !== m_result) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: busy=%b valid=%b result=%0d, required %b %b %0d",
                 i, busy_o, valid_o, result_o, m_phase != 0, m_phase == 6, m_result);
      end
      if (valid_o === 1'b1) begin
        tests_run++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'sd0;
        if (result_o !== exp) begin
          tests_failed++;
          $display("[TB] FAIL random_result cycle %0d: result=%0d, required %0d", i, result_o, exp);
        end
      end
    end
  endtask

  // Reset lands on the edge ending the third MAC cycle of the second sample
  // (accepted at edge 7, MAC counts at edges 8..12); afterwards the impulse
  // must replay from clean history.
  task automatic test_reset_mid_mac();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 0) ? 8'sh7F : 8'sh00);
    end
    tests_run++;
    if (busy_o !== 1'b1 || result_o !== 8'sd31) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: busy=%b result=%0d, required 1 31", busy_o, result_o);
    end
    rst_i = 1'b1;
    step(1'b1, 8'sh00);
    rst_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 8'sd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_mac_reset: busy=%b valid=%b result=%0d, required 0 0 0",
               busy_o, valid_o, result_o);
    end
    test_impulse(3);
  endtask

  initial begin
    test_reset();
    test_idle();
    apply_reset();
    test_impulse(5);
    test_step();
    test_back_to_back();
    test_random();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iir_filter.md
IIR_FILTER -- requirements
Module: iir_filter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset named as the codebase does: clk_i and rst_i.
REQ-002 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 en_i  input  1  sample-valid request; a sample is accepted only when en_i=1 and the block is idle.
REQ-005 d_in  input  8  signed two's-complement input sample x[n], integer scale.
REQ-006 result_o  output  8  signed filter output y[n], registered, held between updates.
REQ-007 valid_o  output  1  one-cycle pulse marking a new result_o.
REQ-008 busy_o  output  1  high while a sample is being processed (any non-IDLE state).

Function
REQ-009 Transfer function SHALL be y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + c1*y[n-1] + c2*y[n-2].
REQ-010 Coefficients SHALL be signed 8-bit Q1.7 constants: b0=0x20 (0.25), b1=0x40 (0.5), b2=0x20 (0.25), c1=0x40 (0.5), c2=0xE0 (-0.25).
REQ-011 Time-shared datapath: exactly one 8x8 signed multiplier and one accumulator.
REQ-012 Accumulator SHALL be 20-bit signed, full-precision sum of five 16-bit products, no intermediate rounding.
REQ-013 Output SHALL be acc arithmetically shifted right by 7 (floor), then saturated to [-128, 127].
REQ-014 The y[n-1] and y[n-2] feedback registers SHALL store the saturated 8-bit result.
REQ-015 FSM states: IDLE, MAC, OUT.
REQ-016 IDLE: busy_o=0; if en_i=1 at a clock edge, capture d_in into x0, clear acc, set count=0, go to MAC; otherwise stay in IDLE.
REQ-017 MAC: 5 cycles, one product per cycle added to acc, in count order 0:b0*x0, 1:b1*x1, 2:b2*x2, 3:c1*y1, 4:c2*y2.
REQ-018 On the count=4 edge: load result_o with the saturated result, set valid_o=1, go to OUT.
REQ-019 OUT: one cycle; on exit shift delay lines (x2<=x1, x1<=x0, y2<=y1, y1<=result), clear valid_o, go to IDLE.
REQ-020 Latency: valid_o rises 5 edges after the accepting edge; with en_i held high a sample is accepted every 7 cycles.
REQ-021 d_in and en_i SHALL be ignored while busy_o=1; no queuing of samples.
REQ-022 result_o SHALL keep its last value when valid_o=0.

Reset
REQ-023 rst_i=1 at an edge SHALL force state=IDLE and clear result_o, valid_o, busy_o, acc, count, x0, x1, x2, y1 and y2 to 0.
REQ-024 Reset SHALL take priority over all other activity, including mid-MAC or during OUT; the in-flight sample is discarded.
REQ-025 After reset release, the first accepted sample SHALL see zero history.

Verification
REQ-026 Impulse: reset, then one cycle d_in=0x7F with en_i=1, then d_in=0 with en_i held 1 -> successive valid results 31, 79, 63, 11, -11 (0x1F, 0x4F, 0x3F, 0x0B, 0xF5).
REQ-027 Step: d_in=0x7F held, en_i=1 -> results 31, 110, then 127 (saturated, raw 174).
REQ-028 Timing: en_i held 1 -> valid_o is one cycle wide every 7 cycles, and busy_o is low only in IDLE cycles.
REQ-029 Idle: en_i=0 for 20 cycles after reset -> busy_o=0, valid_o=0, result_o=0 throughout.
REQ-030 Reset mid-MAC: assert rst_i during the 3rd MAC cycle of the impulse's second sample -> next cycle busy_o=0, valid_o=0, result_o=0; re-running the impulse yields 31, 79, 63 again.
